// File: rtl/i2s_frame_serializer.sv
// I2S / left-justified audio serialiser with a small frame FIFO, last-frame repeat on underrun.
// Optional gain stage (arithmetic right shift at shifter load) enabled by I2S_FRAME_SERIALIZER_GAIN_EN.
module i2s_frame_serializer #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SLOT_BITS    = 32,
    parameter int CLK_DIV      = 4,
    parameter int CHANNELS     = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int LEFT_JUSTIFY = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [SAMPLE_WIDTH-1:0] sample_l,
    input  logic [SAMPLE_WIDTH-1:0] sample_r,
    input  logic                    sample_valid,
`ifdef I2S_FRAME_SERIALIZER_GAIN_EN
    input  logic [2:0]              gain_shift,
`endif
    output logic                    sample_ready,
    output logic                    lrck,
    output logic                    dac,
    output logic [7:0]              underrun_count
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int IDX_W   = PTR_W - 1;
    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int BIT_W   = $clog2(SLOT_BITS);
    localparam int FRAME_W = 2 * SAMPLE_WIDTH;
    // I2S leaves one zero bit after the lrck edge; left-justified starts on it.
    localparam int MSB_POS = (LEFT_JUSTIFY != 0) ? SLOT_BITS - 1 : SLOT_BITS - 2;

    function automatic logic [SLOT_BITS-1:0] format_slot(input logic [SAMPLE_WIDTH-1:0] s);
        logic [SLOT_BITS-1:0] w;
        w = '0;
        w[MSB_POS -: SAMPLE_WIDTH] = s;
        return w;
    endfunction

    logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic                    lrck_q, lrck_d;
    logic                    dac_q, dac_d;
    logic [SLOT_BITS-1:0]    shifter_q, shifter_d;
    logic [SAMPLE_WIDTH-1:0] held_l_q, held_l_d;
    logic [SAMPLE_WIDTH-1:0] held_r_q, held_r_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic                    ready_q, ready_d;
    logic [7:0]              underrun_q, underrun_d;

    logic [FRAME_W-1:0]      fifo_mem [FIFO_DEPTH];
    logic [FRAME_W-1:0]      fifo_head;
    logic [PTR_W-1:0]        occ_next;
    logic                    strobe;
    logic                    boundary;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;
    logic [SAMPLE_WIDTH-1:0] right_src;
    logic [SAMPLE_WIDTH-1:0] load_l;
    logic [SAMPLE_WIDTH-1:0] load_r;

    assign fifo_head = fifo_mem[rd_ptr_q[IDX_W-1:0]];
    assign push      = sample_valid && ready_q;

    always_comb begin
        strobe     = (div_cnt_q == DIV_W'(CLK_DIV - 1));
        boundary   = strobe && (bit_cnt_q == BIT_W'(SLOT_BITS - 1));
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        pop        = boundary && lrck_q && !fifo_empty;

        div_cnt_d  = strobe ? '0 : div_cnt_q + DIV_W'(1);
        bit_cnt_d  = bit_cnt_q;
        if (strobe) begin
            bit_cnt_d = boundary ? '0 : bit_cnt_q + BIT_W'(1);
        end

        held_l_d   = held_l_q;
        held_r_d   = held_r_q;
        underrun_d = underrun_q;
        if (boundary && lrck_q) begin
            if (!fifo_empty) begin
                held_l_d = fifo_head[FRAME_W-1:SAMPLE_WIDTH];
                held_r_d = fifo_head[SAMPLE_WIDTH-1:0];
            end else if (underrun_q != 8'hFF) begin
                underrun_d = underrun_q + 8'd1;
            end
        end

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        occ_next = wr_ptr_d - rd_ptr_d;
        ready_d  = (occ_next != PTR_W'(FIFO_DEPTH));
    end

    // Mono duplicates the left sample into the right slot.
    assign right_src = (CHANNELS == 1) ? held_l_q : held_r_q;

`ifdef I2S_FRAME_SERIALIZER_GAIN_EN
    assign load_l = $unsigned($signed(held_l_d) >>> gain_shift);
    assign load_r = $unsigned($signed(right_src) >>> gain_shift);
`else
    assign load_l = held_l_d;
    assign load_r = right_src;
`endif

    always_comb begin
        shifter_d = shifter_q;
        lrck_d    = lrck_q;
        if (boundary) begin
            if (lrck_q) begin
                shifter_d = format_slot(load_l);
                lrck_d    = 1'b0;
            end else begin
                shifter_d = format_slot(load_r);
                lrck_d    = 1'b1;
            end
        end else if (strobe) begin
            shifter_d = {shifter_q[SLOT_BITS-2:0], 1'b0};
        end
        dac_d = shifter_d[SLOT_BITS-1];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            lrck_q     <= 1'b0;
            dac_q      <= 1'b0;
            shifter_q  <= '0;
            held_l_q   <= '0;
            held_r_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ready_q    <= 1'b0;
            underrun_q <= 8'd0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            lrck_q     <= lrck_d;
            dac_q      <= dac_d;
            shifter_q  <= shifter_d;
            held_l_q   <= held_l_d;
            held_r_q   <= held_r_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ready_q    <= ready_d;
            underrun_q <= underrun_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            fifo_mem[wr_ptr_q[IDX_W-1:0]] <= {sample_l, sample_r};
        end
    end

    assign sample_ready   = ready_q;
    assign lrck           = lrck_q;
    assign dac            = dac_q;
    assign underrun_count = underrun_q;

endmodule

// File: tb/tb_i2s_frame_serializer.sv
// Self-checking bench: default stereo I2S instance plus a small mono left-justified instance,
// both compared every cycle against a frame-level reference model.
module tb_i2s_frame_serializer;

    logic        clk;
    logic        rst_n [2];
    logic        valid [2];
    logic [15:0] in_l  [2];
    logic [15:0] in_r  [2];
    logic        ready [2];
    logic        lrck  [2];
    logic        dac   [2];
    logic [7:0]  uc    [2];

    int n_checks = 0;
    int n_fail   = 0;

    i2s_frame_serializer u_dut0 (
        .clk            (clk),
        .reset_n        (rst_n[0]),
        .sample_l       (in_l[0]),
        .sample_r       (in_r[0]),
        .sample_valid   (valid[0]),
`ifdef I2S_FRAME_SERIALIZER_GAIN_EN
        .gain_shift     (3'd0),
`endif
        .sample_ready   (ready[0]),
        .lrck           (lrck[0]),
        .dac            (dac[0]),
        .underrun_count (uc[0])
    );

    i2s_frame_serializer #(
        .SAMPLE_WIDTH (4),
        .SLOT_BITS    (6),
        .CLK_DIV      (2),
        .CHANNELS     (1),
        .FIFO_DEPTH   (2),
        .LEFT_JUSTIFY (1)
    ) u_dut1 (
        .clk            (clk),
        .reset_n        (rst_n[1]),
        .sample_l       (in_l[1][3:0]),
        .sample_r       (in_r[1][3:0]),
        .sample_valid   (valid[1]),
`ifdef I2S_FRAME_SERIALIZER_GAIN_EN
        .gain_shift     (3'd0),
`endif
        .sample_ready   (ready[1]),
        .lrck           (lrck[1]),
        .dac            (dac[1]),
        .underrun_count (uc[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Per-instance configuration
    function automatic int p_w(input int id);   return (id == 0) ? 16 : 4; endfunction
    function automatic int p_s(input int id);   return (id == 0) ? 32 : 6; endfunction
    function automatic int p_d(input int id);   return (id == 0) ? 4  : 2; endfunction
    function automatic int p_ch(input int id);  return (id == 0) ? 2  : 1; endfunction
    function automatic int p_dep(input int id); return (id == 0) ? 4  : 2; endfunction
    function automatic int p_lj(input int id);  return (id == 0) ? 0  : 1; endfunction

    // Reference model state: edges since reset, queued frames, held frame, underruns
    int          m_k   [2];
    int          m_cnt [2];
    logic [15:0] m_fl  [2][8];
    logic [15:0] m_fr  [2][8];
    logic [15:0] m_hl  [2];
    logic [15:0] m_hr  [2];
    int          m_uc  [2];
    bit          m_ready [2];

    task automatic model_edge(input int id);
        int per;
        logic [15:0] msk;
        if (!rst_n[id]) begin
            m_k[id] = 0; m_cnt[id] = 0; m_hl[id] = '0; m_hr[id] = '0;
            m_uc[id] = 0; m_ready[id] = 1'b0;
        end else begin
            per = 2 * p_s(id) * p_d(id);
            msk = 16'((32'd1 << p_w(id)) - 1);
            m_k[id]++;
            if (m_k[id] % per == 0) begin
                if (m_cnt[id] > 0) begin
                    m_hl[id] = m_fl[id][0];
                    m_hr[id] = m_fr[id][0];
                    for (int i = 0; i < 7; i++) begin
                        m_fl[id][i] = m_fl[id][i+1];
                        m_fr[id][i] = m_fr[id][i+1];
                    end
                    m_cnt[id]--;
                end else if (m_uc[id] < 255) begin
                    m_uc[id]++;
                end
            end
            if (valid[id] && m_ready[id]) begin
                m_fl[id][m_cnt[id]] = in_l[id] & msk;
                m_fr[id][m_cnt[id]] = in_r[id] & msk;
                m_cnt[id]++;
            end
            m_ready[id] = (m_cnt[id] < p_dep(id));
        end
    endtask

    function automatic int exp_lrck(input int id);
        int b;
        b = (m_k[id] / p_d(id)) % (2 * p_s(id));
        return (b >= p_s(id)) ? 1 : 0;
    endfunction

    function automatic int exp_dac(input int id);
        int b, j, w;
        logic [15:0] s;
        b = (m_k[id] / p_d(id)) % (2 * p_s(id));
        j = b % p_s(id);
        w = p_w(id);
        s = ((b >= p_s(id)) && p_ch(id) == 2) ? m_hr[id] : m_hl[id];
        if (p_lj(id) != 0) return (j < w) ? int'(s[w-1-j]) : 0;
        return (j >= 1 && j <= w) ? int'(s[w-j]) : 0;
    endfunction

    task automatic check(input string name, input int id, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s dut%0d k=%0d: got %0d, expected %0d", name, id, m_k[id], act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        for (int id = 0; id < 2; id++) begin
            check("lrck", id, int'(lrck[id]), exp_lrck(id));
            check("dac", id, int'(dac[id]), exp_dac(id));
            check("ready", id, int'(ready[id]), int'(m_ready[id]));
            check("underrun", id, int'(uc[id]), m_uc[id]);
        end
    endtask

    task automatic run_to(input int id, input int target);
        int guard;
        guard = 0;
        while (m_k[id] < target) begin
            step();
            guard++;
            if (guard > 20000) begin
                check("run_to_bound", id, m_k[id], target);
                break;
            end
        end
    endtask

    task automatic reset_dut(input int id);
        rst_n[id] = 1'b0;
        valid[id] = 1'b0;
        step();
        rst_n[id] = 1'b1;
    endtask

    task automatic push_frame(input int id, input logic [15:0] l, input logic [15:0] r);
        bit got;
        valid[id] = 1'b1;
        in_l[id]  = l;
        in_r[id]  = r;
        for (int g = 0; g < 2000; g++) begin
            got = m_ready[id];
            step();
            if (got) break;
        end
        valid[id] = 1'b0;
    endtask

    // Serial bits of one whole frame, sampled mid bit period, MSB first
    task automatic capture_frame(input int id, input int frame_idx, output logic [63:0] bits);
        int per, d;
        per  = 2 * p_s(id) * p_d(id);
        d    = p_d(id);
        bits = '0;
        for (int i = 0; i < 2 * p_s(id); i++) begin
            run_to(id, frame_idx * per + i * d + d / 2);
            bits = {bits[62:0], dac[id]};
        end
    endtask

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic [31:0] exp_left;
        logic [31:0] exp_right;
    } vec_t;

    vec_t        vecs [4];
    logic [63:0] cap;
    int          acc;

    initial begin
        vecs[0] = '{16'h8001, 16'h7FFE, 32'h4000_8000, 32'h3FFF_0000};
        vecs[1] = '{16'h1234, 16'h4321, 32'h091A_0000, 32'h2190_8000};
        vecs[2] = '{16'hFFFF, 16'h0000, 32'h7FFF_8000, 32'h0000_0000};
        vecs[3] = '{16'h0000, 16'hAAAA, 32'h0000_0000, 32'h5555_0000};

        for (int id = 0; id < 2; id++) begin
            rst_n[id] = 1'b0; valid[id] = 1'b0; in_l[id] = '0; in_r[id] = '0;
        end
        step();
        step();
        for (int id = 0; id < 2; id++) begin
            check("reset_ready", id, int'(ready[id]), 0);
            check("reset_lrck", id, int'(lrck[id]), 0);
            check("reset_dac", id, int'(dac[id]), 0);
            check("reset_underrun", id, int'(uc[id]), 0);
            rst_n[id] = 1'b1;
        end
        step();
        check("ready_after_release", 0, int'(ready[0]), 1);

        // Table: one frame per entry, serialised bits of frame 1 compared with constants
        for (int v = 0; v < 4; v++) begin
            reset_dut(0);
            push_frame(0, vecs[v].l, vecs[v].r);
            run_to(0, 255);
            check("lrck_before_256", 0, int'(lrck[0]), 1);
            run_to(0, 256);
            check("lrck_at_256", 0, int'(lrck[0]), 0);
            capture_frame(0, 1, cap);
            $display("vector %0d L=%h R=%h left_slot=%h right_slot=%h", v, vecs[v].l, vecs[v].r,
                     cap[63:32], cap[31:0]);
            check("left_slot", 0, int'(cap[63:32]), int'(vecs[v].exp_left));
            check("right_slot", 0, int'(cap[31:0]), int'(vecs[v].exp_right));
        end

        // valid held high from reset: four accepted, then one per frame
        reset_dut(0);
        valid[0] = 1'b1;
        acc = 0;
        while (m_k[0] < 254) begin
            in_l[0] = 16'($urandom); in_r[0] = 16'($urandom);
            if (ready[0]) acc++;
            step();
        end
        check("fill_accepted", 0, acc, 4);
        check("fill_ready_low", 0, int'(ready[0]), 0);
        while (m_k[0] < 256) begin
            if (ready[0]) acc++;
            step();
        end
        check("ready_after_pop", 0, int'(ready[0]), 1);
        while (m_k[0] < 300) begin
            if (ready[0]) acc++;
            step();
        end
        check("fill_accepted_next", 0, acc, 5);
        valid[0] = 1'b0;
        $display("fill: %0d frames accepted by clk %0d", acc, m_k[0]);

        // Reset mid right slot with three frames queued
        reset_dut(0);
        push_frame(0, 16'h1111, 16'h2222);
        push_frame(0, 16'h3333, 16'h4444);
        push_frame(0, 16'h5555, 16'h6666);
        run_to(0, 200);
        rst_n[0] = 1'b0;
        step();
        check("midrst_lrck", 0, int'(lrck[0]), 0);
        check("midrst_dac", 0, int'(dac[0]), 0);
        check("midrst_underrun", 0, int'(uc[0]), 0);
        check("midrst_ready", 0, int'(ready[0]), 0);
        rst_n[0] = 1'b1;
        step();
        check("midrst_ready_release", 0, int'(ready[0]), 1);
        run_to(0, 256);
        check("midrst_flushed", 0, int'(uc[0]), 1);
        $display("mid-frame reset: underrun_count=%0d after first boundary", uc[0]);

        // Random traffic, checked every cycle against the model
        reset_dut(0);
        for (int c = 0; c < 3072; c++) begin
            valid[0] = ($urandom_range(0, 99) < 3);
            in_l[0]  = 16'($urandom);
            in_r[0]  = 16'($urandom);
            step();
        end
        valid[0] = 1'b0;
        $display("random traffic: underrun_count=%0d", uc[0]);

        // Mono left-justified instance: repeat and underrun saturation
        reset_dut(1);
        push_frame(1, 16'h000A, 16'h0005);
        capture_frame(1, 1, cap);
        $display("mono LJ frame 1 bits=%h", cap[11:0]);
        check("mono_lj_frame1", 1, int'(cap[11:0]), 32'hA28);
        capture_frame(1, 2, cap);
        $display("mono LJ frame 2 bits=%h", cap[11:0]);
        check("mono_lj_repeat", 1, int'(cap[11:0]), 32'hA28);
        run_to(1, 24 * 255);
        check("underrun_254", 1, int'(uc[1]), 254);
        run_to(1, 24 * 256);
        check("underrun_255", 1, int'(uc[1]), 255);
        run_to(1, 24 * 257);
        check("underrun_sat", 1, int'(uc[1]), 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
